mem_read_arbiter: RTL

- Shares one pipelined memory read port between the core's instruction-fetch requester (port 0) and load requester (port 1).
- Grants at most one request per cycle, using round-robin or fixed load-first priority.
- Tracks in-flight requests in a LATENCY-deep tag pipeline and routes each returned doubleword to the requester that issued it.
- Sits between the core's fetch/load logic and the single-port `mem` read interface.

---
 rtl/mem_read_arbiter.sv | 71 +++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// Two-requester arbiter (fetch = port 0, load = port 1) in front of one pipelined
// memory read port. A tag pipeline routes each returned doubleword to its requester.
module mem_read_arbiter #(
    parameter int LATENCY   = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [0:60] f_addr,
    output logic        f_ready,
    output logic        f_rvalid,
    output logic [0:63] f_rdata,
    input  logic        l_valid,
    input  logic [0:60] l_addr,
    output logic        l_ready,
    output logic        l_rvalid,
    output logic [0:63] l_rdata,
    output logic        mem_req,
    output logic [0:60] mem_addr,
    input  logic [0:63] mem_rdata,
    output logic        busy
);

    // Handshake: a request is taken at a posedge where x_valid & x_ready are both
    // high; x_ready is combinational and never high on both ports at once.
    // Responses (x_rvalid) are single-cycle pulses with no back-pressure.

    logic                 r_last_grant;   // 0 = fetch, 1 = load
    logic [LATENCY-1:0]   r_vld;
    logic [LATENCY-1:0]   r_tag;
    logic                 w_grant_l;

    always_comb begin
        w_grant_l = l_valid;
        if (f_valid && l_valid) begin
            w_grant_l = (PRIO_MODE != 0) ? 1'b1 : ~r_last_grant;
        end
    end

    assign l_ready  = w_grant_l;
    assign f_ready  = f_valid & ~w_grant_l;
    assign mem_req  = f_ready | l_ready;
    assign mem_addr = l_ready ? l_addr : f_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_vld        <= '0;
            r_tag        <= '0;
        end else begin
            if (mem_req) begin
                r_last_grant <= l_ready;
            end
            r_vld[0] <= mem_req;
            r_tag[0] <= l_ready;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // The last stage lines up with mem_rdata for the request that produced it.
    assign f_rvalid = r_vld[LATENCY-1] & ~r_tag[LATENCY-1];
    assign l_rvalid = r_vld[LATENCY-1] &  r_tag[LATENCY-1];
    assign f_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;
    assign busy     = |r_vld;

endmodule
